// File: rtl/traffic_light_ctrl_if.sv
// rtl/traffic_light_ctrl_if.sv - demand inputs and lamp outputs of the intersection sequencer
interface traffic_light_ctrl_if;
  logic       en;
  logic       side_car;
  logic       ped_req;
  logic [2:0] main_rgy;
  logic [2:0] side_rgy;
  logic       walk;
  logic       ped_pend;
  logic [2:0] state;

  modport master (
    output en, side_car, ped_req,
    input  main_rgy, side_rgy, walk, ped_pend, state
  );

  modport slave (
    input  en, side_car, ped_req,
    output main_rgy, side_rgy, walk, ped_pend, state
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - main/side road sequencer with pedestrian walk phase
// Main green rests until demand; every other phase lasts a fixed number of en ticks.
module traffic_light_ctrl #(
  parameter int T_MG   = 20,
  parameter int T_Y    = 3,
  parameter int T_AR   = 1,
  parameter int T_SG   = 10,
  parameter int T_WALK = 8,
  parameter int CW     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_light_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    PH_MG   = 3'd0,
    PH_MY   = 3'd1,
    PH_AR1  = 3'd2,
    PH_WALK = 3'd3,
    PH_SG   = 3'd4,
    PH_SY   = 3'd5,
    PH_AR2  = 3'd6,
    PH_BAD  = 3'd7
  } phase_e;

  localparam logic [CW-1:0] LAST_MG   = CW'(T_MG - 1);
  localparam logic [CW-1:0] LAST_Y    = CW'(T_Y - 1);
  localparam logic [CW-1:0] LAST_AR   = CW'(T_AR - 1);
  localparam logic [CW-1:0] LAST_SG   = CW'(T_SG - 1);
  localparam logic [CW-1:0] LAST_WALK = CW'(T_WALK - 1);

  phase_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ped_pend_q, ped_pend_d;
  logic [CW-1:0] last_cnt;
  logic          demand;

  assign demand = bus.side_car | ped_pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PH_MG;
      cnt_q      <= '0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  always_comb begin
    last_cnt = '0;
    case (state_q)
      PH_MG:         last_cnt = LAST_MG;
      PH_MY, PH_SY:  last_cnt = LAST_Y;
      PH_AR1, PH_AR2: last_cnt = LAST_AR;
      PH_WALK:       last_cnt = LAST_WALK;
      PH_SG:         last_cnt = LAST_SG;
      default:       last_cnt = '0;
    endcase
  end

  // In MG without demand the timer parks on its last count, so late demand exits on the next tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == PH_BAD) begin
      state_d = PH_MG;
      cnt_d   = '0;
    end else if (bus.en) begin
      if (cnt_q < last_cnt) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        case (state_q)
          PH_MG:   state_d = demand ? PH_MY : PH_MG;
          PH_MY:   state_d = PH_AR1;
          PH_AR1:  state_d = ped_pend_q ? PH_WALK : PH_SG;
          PH_WALK: state_d = bus.side_car ? PH_SG : PH_AR2;
          PH_SG:   state_d = PH_SY;
          PH_SY:   state_d = PH_AR2;
          PH_AR2:  state_d = PH_MG;
          default: state_d = PH_MG;
        endcase
        if (state_d != state_q) begin
          cnt_d = '0;
        end
      end
    end
  end

  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == PH_WALK && state_q != PH_WALK) begin
      ped_pend_d = 1'b0;
    end else if (bus.ped_req && state_q != PH_WALK) begin
      ped_pend_d = 1'b1;
    end
  end

  always_comb begin
    bus.main_rgy = 3'b100;
    bus.side_rgy = 3'b100;
    bus.walk     = 1'b0;
    case (state_q)
      PH_MG:   bus.main_rgy = 3'b001;
      PH_MY:   bus.main_rgy = 3'b010;
      PH_SG:   bus.side_rgy = 3'b001;
      PH_SY:   bus.side_rgy = 3'b010;
      PH_WALK: bus.walk     = 1'b1;
      default: ;
    endcase
  end

  assign bus.ped_pend = ped_pend_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - randomized and directed checks of traffic_light_ctrl against a phase model
module tb_traffic_light_ctrl;
  localparam int T_MG = 4, T_Y = 2, T_AR = 1, T_SG = 3, T_WALK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  traffic_light_ctrl_if bus();

  traffic_light_ctrl #(
    .T_MG(T_MG), .T_Y(T_Y), .T_AR(T_AR), .T_SG(T_SG), .T_WALK(T_WALK), .CW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      0:       return T_MG;
      1, 5:    return T_Y;
      2, 6:    return T_AR;
      3:       return T_WALK;
      4:       return T_SG;
      default: return 1;
    endcase
  endfunction

  function automatic int succ(input int p, input bit sc, input bit pd);
    case (p)
      0:       return 1;
      1:       return 2;
      2:       return pd ? 3 : 4;
      3:       return sc ? 4 : 6;
      4:       return 5;
      5:       return 6;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] main_of(input int p);
    return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] side_of(input int p);
    return (p == 4) ? 3'b001 : (p == 5) ? 3'b010 : 3'b100;
  endfunction

  // Model: phase plus en ticks still owed in it.
  int m_ph, m_rem, m_nxt;
  bit m_pend;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_rem = T_MG; m_pend = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_nxt = m_ph;
      if (bus.en) begin
        if (m_rem > 1) m_rem = m_rem - 1;
        else if (m_ph != 0 || bus.side_car || m_pend) m_nxt = succ(m_ph, bus.side_car, m_pend);
      end
      if (m_nxt == 3 && m_ph != 3) m_pend = 1'b0;
      else if (bus.ped_req && m_ph != 3) m_pend = 1'b1;
      if (m_nxt != m_ph) begin
        m_ph = m_nxt;
        m_rem = dur(m_nxt);
      end
    end
  end

  logic [2:0] prev_state;
  bit prev_en, prev_rst, have_prev = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("state", bus.state, m_ph);
      check("main_rgy", bus.main_rgy, main_of(m_ph));
      check("side_rgy", bus.side_rgy, side_of(m_ph));
      check("walk", bus.walk, (m_ph == 3));
      check("ped_pend", bus.ped_pend, m_pend);
      if (have_prev && !prev_en && !prev_rst) check("hold_no_en", bus.state, prev_state);
      prev_en = bus.en; prev_rst = rst; prev_state = bus.state; have_prev = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_n(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int exp2 [14] = '{0,0,0,0,1,1,2,4,4,4,5,5,6,0};
  int exp3 [11] = '{0,0,0,0,1,1,2,3,3,6,0};
  int exp4 [16] = '{0,0,0,0,1,1,2,3,3,4,4,4,5,5,6,0};

  initial begin
    bus.en = 1'b1; bus.side_car = 1'b0; bus.ped_req = 1'b0;

    reset_n(2);
    for (int c = 0; c < 50; c++) begin
      check("t1_lamps", {bus.main_rgy, bus.side_rgy, bus.walk}, 7'b001_100_0);
      cyc();
    end

    bus.side_car = 1'b1;
    reset_n(2);
    for (int c = 0; c < 14; c++) begin
      check("t2_state", bus.state, exp2[c]);
      check("t2_side", bus.side_rgy, (c >= 7 && c <= 9) ? 3'b001 : (c == 10 || c == 11) ? 3'b010 : 3'b100);
      cyc();
    end

    bus.side_car = 1'b0;
    reset_n(2);
    for (int c = 0; c < 11; c++) begin
      check("t3_state", bus.state, exp3[c]);
      check("t3_pend", bus.ped_pend, (c >= 2 && c <= 6));
      check("t3_walk", bus.walk, (c == 7 || c == 8));
      bus.ped_req = (c == 1);
      cyc();
    end
    bus.ped_req = 1'b0;

    bus.side_car = 1'b1;
    reset_n(2);
    for (int c = 0; c < 16; c++) begin
      check("t4_state", bus.state, exp4[c]);
      bus.ped_req = (c == 1);
      cyc();
    end
    bus.ped_req = 1'b0;

    reset_n(2);
    for (int c = 0; c < 120; c++) begin
      if (c == 15) check("t5_mg_end", bus.state, 0);
      if (c == 16) check("t5_my_start", bus.state, 1);
      if (c == 23) check("t5_my_end", bus.state, 1);
      if (c == 24) check("t5_ar1", bus.state, 2);
      bus.en = (c % 4 == 3);
      cyc();
    end
    bus.en = 1'b1;

    reset_n(2);
    begin
      int k = 0;
      while (bus.state != 3'd4 && k < 40) begin
        cyc();
        k++;
      end
    end
    check("t6_reach_sg", bus.state, 4);
    bus.ped_req = 1'b1;
    cyc();
    bus.ped_req = 1'b0;
    check("t6_pend_in_sg", bus.ped_pend, 1);
    check("t6_still_sg", bus.state, 4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_rst_state", bus.state, 0);
    check("t6_rst_lamps", {bus.main_rgy, bus.side_rgy, bus.walk}, 7'b001_100_0);
    check("t6_rst_pend", bus.ped_pend, 0);
    repeat (3) cyc();
    check("t6_cnt_cleared_mg", bus.state, 0);
    cyc();
    check("t6_cnt_cleared_my", bus.state, 1);

    reset_n(1);
    for (int c = 0; c < 3000; c++) begin
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.side_car = ($urandom_range(0, 9) < 3);
      bus.ped_req  = ($urandom_range(0, 15) == 0);
      rst          = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
